pdm_stereo_decimator: RTL

PDM_STEREO_DECIMATOR -- requirements
Module: pdm_stereo_decimator

---
 rtl/pdm_stereo_decimator.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pdm_stereo_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_stereo_decimator
//  Purpose  : Drives a PDM microphone clock and captures one or two channels
//             from a shared data line (left on the falling clock edge, right
//             on the rising edge).  Each channel passes through a CIC
//             decimator and a moving-average filter.  The result is a signed
//             PCM pair with a valid/ready handshake and a sticky overrun flag.
//  Revision : 1.0  initial release
// ============================================================================
module pdm_stereo_decimator #(
   parameter int CLK_DIV    = 16,
   parameter int DECIMATION = 64,
   parameter int CIC_STAGES = 4,
   parameter int AVG_TAPS   = 8,
   parameter int OUT_WIDTH  = 16,
   parameter int STEREO     = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   output logic                 pdm_clk,
   input  logic                 pdm_data,
   output logic [OUT_WIDTH-1:0] out_left,
   output logic [OUT_WIDTH-1:0] out_right,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overrun,
   input  logic                 overrun_clr
);

   localparam int DEC_W  = $clog2(DECIMATION);
   localparam int ACC_W  = CIC_STAGES * DEC_W + 2;
   localparam int TAP_W  = $clog2(AVG_TAPS);
   localparam int SUM_W  = OUT_WIDTH + TAP_W;
   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int DISC_W = $clog2(CIC_STAGES + 1);
   localparam int NCH    = (STEREO != 0) ? 2 : 1;

   // -------------------------------------------------------------------------
   // Microphone clock generation
   // -------------------------------------------------------------------------
   logic [DIV_W-1:0] div_q, div_d;
   logic             pclk_q, pclk_d;
   logic             div_end_w;
   logic             ev_l_w;
   logic             ev_r_w;

   assign div_end_w = enable & (div_q == DIV_W'(CLK_DIV - 1));
   // The last clk of each half-period is where the data line is sampled:
   // end of the high phase carries left, end of the low phase carries right.
   assign ev_l_w    = div_end_w &  pclk_q;
   assign ev_r_w    = div_end_w & ~pclk_q;

   // Next divide count and clock level; both park at zero while disabled
   always_comb begin
      div_d  = '0;
      pclk_d = 1'b0;
      if (enable) begin
         div_d  = div_end_w ? '0 : div_q + 1'b1;
         pclk_d = div_end_w ? ~pclk_q : pclk_q;
      end
   end

   // Divide counter and microphone clock registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         pclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         pclk_q <= pclk_d;
      end
   end

   // -------------------------------------------------------------------------
   // Decimation timing: PDM period counter, start-up discard, pipeline flags
   // -------------------------------------------------------------------------
   logic [DEC_W-1:0]  per_q, per_d;
   logic [DISC_W-1:0] disc_q, disc_d;
   logic [TAP_W-1:0]  ptr_q, ptr_d;
   logic              cvld_q, cvld_d;
   logic              dec_ev_w;
   logic              keep_ev_w;
   logic              new_pair_w;

   // The period closes on the 0->1 toggle, which is also the right-sample
   // event, so mono and stereo builds share the same decimation timing.
   assign dec_ev_w   = ev_r_w & (per_q == {DEC_W{1'b1}});
   // The first CIC_STAGES outputs still contain the comb start-up transient
   assign keep_ev_w  = dec_ev_w & (disc_q == DISC_W'(CIC_STAGES));
   assign new_pair_w = cvld_q & enable;

   // Next-state for period counter, discard counter, tap pointer, comb flag
   always_comb begin
      per_d  = '0;
      disc_d = '0;
      ptr_d  = '0;
      cvld_d = 1'b0;
      if (enable) begin
         per_d  = ev_r_w ? per_q + 1'b1 : per_q;
         disc_d = (dec_ev_w && (disc_q != DISC_W'(CIC_STAGES))) ? disc_q + 1'b1 : disc_q;
         ptr_d  = new_pair_w ? ptr_q + 1'b1 : ptr_q;
         cvld_d = keep_ev_w;
      end
   end

   // Decimation timing registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_q  <= '0;
         disc_q <= '0;
         ptr_q  <= '0;
         cvld_q <= 1'b0;
      end else begin
         per_q  <= per_d;
         disc_q <= disc_d;
         ptr_q  <= ptr_d;
         cvld_q <= cvld_d;
      end
   end

   // -------------------------------------------------------------------------
   // Per-channel CIC decimator and moving average
   // -------------------------------------------------------------------------
   logic [NCH-1:0]                ch_ev_w;
   logic [NCH-1:0][OUT_WIDTH-1:0] avg_w;

   assign ch_ev_w[0] = ev_l_w;

   generate
      if (NCH == 2) begin : g_ev_right
         assign ch_ev_w[1] = ev_r_w;
      end
   endgenerate

   generate
      for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
         logic [ACC_W-1:0]                   x_w;
         logic [ACC_W-1:0]                   cout_w;
         logic [OUT_WIDTH-1:0]               comb_q;
         logic [AVG_TAPS-1:0][OUT_WIDTH-1:0] hist_w;
         logic [OUT_WIDTH-1:0]               old_w;
         logic [SUM_W-1:0]                   sum_q, sum_d;

         // A one bit counts +1, a zero bit counts -1
         assign x_w = pdm_data ? ACC_W'(1) : {ACC_W{1'b1}};

         for (genvar s = 0; s < CIC_STAGES; s++) begin : g_int
            logic [ACC_W-1:0] acc_q;
            logic [ACC_W-1:0] in_w;

            if (s == 0) begin : g_src_bit
               assign in_w = x_w;
            end else begin : g_src_prev
               assign in_w = g_int[s-1].acc_q;
            end

            // Integrator stage, wraps freely, steps once per channel sample
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  acc_q <= '0;
               end else if (!enable) begin
                  acc_q <= '0;
               end else if (ch_ev_w[ch]) begin
                  acc_q <= acc_q + in_w;
               end
            end
         end

         for (genvar s = 0; s < CIC_STAGES; s++) begin : g_comb
            logic [ACC_W-1:0] src_w;
            logic [ACC_W-1:0] dly_q;
            logic [ACC_W-1:0] diff_w;

            if (s == 0) begin : g_src_int
               assign src_w = g_int[CIC_STAGES-1].acc_q;
            end else begin : g_src_comb
               assign src_w = g_comb[s-1].diff_w;
            end

            assign diff_w = src_w - dly_q;

            // Comb delay element, advances only on decimation events
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  dly_q <= '0;
               end else if (!enable) begin
                  dly_q <= '0;
               end else if (dec_ev_w) begin
                  dly_q <= src_w;
               end
            end
         end

         assign cout_w = g_comb[CIC_STAGES-1].diff_w;

         if (OUT_WIDTH < ACC_W) begin : g_trunc
            logic unused_lsb;
            assign unused_lsb = ^cout_w[ACC_W-OUT_WIDTH-1:0];
         end

         // Comb output register keeps the top OUT_WIDTH bits
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               comb_q <= '0;
            end else if (!enable) begin
               comb_q <= '0;
            end else if (dec_ev_w) begin
               comb_q <= cout_w[ACC_W-1 -: OUT_WIDTH];
            end
         end

         for (genvar t = 0; t < AVG_TAPS; t++) begin : g_tap
            logic [OUT_WIDTH-1:0] tap_q;

            assign hist_w[t] = tap_q;

            // History slot t is overwritten when the pointer reaches it
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  tap_q <= '0;
               end else if (!enable) begin
                  tap_q <= '0;
               end else if (new_pair_w && (ptr_q == TAP_W'(t))) begin
                  tap_q <= comb_q;
               end
            end
         end

         assign old_w = hist_w[ptr_q];
         assign sum_d = sum_q
                      + {{TAP_W{comb_q[OUT_WIDTH-1]}}, comb_q}
                      - {{TAP_W{old_w[OUT_WIDTH-1]}}, old_w};
         // Dropping the low TAP_W bits of the sign-extended sum is the
         // arithmetic right shift; what remains is exactly OUT_WIDTH wide.
         assign avg_w[ch] = sum_d[SUM_W-1:TAP_W];

         // Running sum: add the newest sample, retire the oldest
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sum_q <= '0;
            end else if (!enable) begin
               sum_q <= '0;
            end else if (new_pair_w) begin
               sum_q <= sum_d;
            end
         end
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Output register with valid/ready handshake and overrun detection
   // -------------------------------------------------------------------------
   logic [OUT_WIDTH-1:0] left_q, left_d;
   logic [OUT_WIDTH-1:0] right_q, right_d;
   logic                 valid_q, valid_d;
   logic                 ovr_q, ovr_d;
   logic [OUT_WIDTH-1:0] new_right_w;

   generate
      if (NCH == 2) begin : g_right
         assign new_right_w = avg_w[1];
      end else begin : g_mono
         assign new_right_w = '0;
      end
   endgenerate

   // Load, hold or drop the incoming pair; a drop outranks an overrun clear
   always_comb begin
      left_d  = left_q;
      right_d = right_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (overrun_clr) begin
         ovr_d = 1'b0;
      end
      if (!enable) begin
         left_d  = '0;
         right_d = '0;
         valid_d = 1'b0;
      end else if (valid_q && !out_ready) begin
         if (new_pair_w) begin
            ovr_d = 1'b1;
         end
      end else if (new_pair_w) begin
         left_d  = avg_w[0];
         right_d = new_right_w;
         valid_d = 1'b1;
      end else begin
         valid_d = 1'b0;
      end
   end

   // Output registers; overrun survives enable going low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left_q  <= '0;
         right_q <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         left_q  <= left_d;
         right_q <= right_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign pdm_clk   = pclk_q;
   assign out_left  = left_q;
   assign out_right = right_q;
   assign out_valid = valid_q;
   assign overrun   = ovr_q;

endmodule
`default_nettype wire
